// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP FSM
// with an instruction-class register latched when leaving DECODE.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrc,
    output logic [1:0] ToReg,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [4:0] {
        C_NONE, C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL, C_SRL, C_JR,
        C_LW, C_SW, C_BEQ, C_ADDI, C_ORI, C_LUI, C_J, C_JAL, C_ILL
    } cls_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] AS_REG   = 2'b00;
    localparam logic [1:0] AS_IMM   = 2'b01;
    localparam logic [1:0] AS_SHAMT = 2'b10;

    localparam logic [1:0] TR_DM  = 2'b00;
    localparam logic [1:0] TR_ALU = 2'b01;
    localparam logic [1:0] TR_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    function automatic cls_e decode_cls(input logic [5:0] o, input logic [5:0] f);
        cls_e c;
        c = C_ILL;
        case (o)
            OP_RTYPE: begin
                case (f)
                    F_ADD:   c = C_ADD;
                    F_SUB:   c = C_SUB;
                    F_AND:   c = C_AND;
                    F_OR:    c = C_OR;
                    F_SLT:   c = C_SLT;
                    F_SLL:   c = C_SLL;
                    F_SRL:   c = C_SRL;
                    F_JR:    c = C_JR;
                    default: c = C_ILL;
                endcase
            end
            OP_LW:   c = C_LW;
            OP_SW:   c = C_SW;
            OP_BEQ:  c = C_BEQ;
            OP_ADDI: c = C_ADDI;
            OP_ORI:  c = C_ORI;
            OP_LUI:  c = C_LUI;
            OP_J:    c = C_J;
            OP_JAL:  c = C_JAL;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    // EXEC and WB share these so the ALU sees a stable setup across both cycles.
    function automatic logic [1:0] alu_src_of(input cls_e c);
        logic [1:0] s;
        case (c)
            C_SLL, C_SRL:                        s = AS_SHAMT;
            C_LW, C_SW, C_ADDI, C_ORI, C_LUI:    s = AS_IMM;
            default:                             s = AS_REG;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] alu_op_of(input cls_e c);
        logic [3:0] a;
        case (c)
            C_SUB, C_BEQ: a = ALU_SUB;
            C_AND:        a = ALU_AND;
            C_OR, C_ORI:  a = ALU_OR;
            C_SLT:        a = ALU_SLT;
            C_SLL:        a = ALU_SLL;
            C_SRL:        a = ALU_SRL;
            C_LUI:        a = ALU_LUI;
            default:      a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic logic is_rtype(input cls_e c);
        return (c == C_ADD) || (c == C_SUB) || (c == C_AND) || (c == C_OR) ||
               (c == C_SLT) || (c == C_SLL) || (c == C_SRL);
    endfunction

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    cls_e       dec_cls;

    logic       pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;
    logic       illegal_c;
    logic [1:0] reg_dst_c, alu_src_c, to_reg_c, npc_op_c;
    logic [3:0] alu_op_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        dec_cls     = decode_cls(op, funct);
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        illegal_c   = 1'b0;
        reg_dst_c   = RD_RT;
        alu_src_c   = AS_REG;
        to_reg_c    = TR_DM;
        alu_op_c    = ALU_ADD;
        npc_op_c    = NPC_PC4;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            // Only here are op/funct looked at directly; later states use cls_q.
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_J: begin
                        pc_write_c = 1'b1;
                        npc_op_c   = NPC_J;
                        state_d    = S_FETCH;
                    end
                    C_JAL: begin
                        pc_write_c  = 1'b1;
                        npc_op_c    = NPC_J;
                        reg_write_c = 1'b1;
                        reg_dst_c   = RD_RA;
                        to_reg_c    = TR_PC4;
                        state_d     = S_FETCH;
                    end
                    C_ILL:   state_d = S_TRAP;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_src_c = alu_src_of(cls_q);
                alu_op_c  = alu_op_of(cls_q);
                case (cls_q)
                    C_BEQ: begin
                        pc_write_c = zero;
                        npc_op_c   = NPC_BR;
                        state_d    = S_FETCH;
                    end
                    C_JR: begin
                        pc_write_c = 1'b1;
                        npc_op_c   = NPC_JR;
                        state_d    = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end

            S_MEM: begin
                if (cls_q == C_LW) begin
                    mem_read_c = 1'b1;
                end else begin
                    mem_write_c = 1'b1;
                end
                if (mem_ready) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                reg_write_c = 1'b1;
                alu_src_c   = alu_src_of(cls_q);
                alu_op_c    = alu_op_of(cls_q);
                if (cls_q == C_LW) begin
                    reg_dst_c = RD_RT;
                    to_reg_c  = TR_DM;
                end else if (is_rtype(cls_q)) begin
                    reg_dst_c = RD_RD;
                    to_reg_c  = TR_ALU;
                end else begin
                    reg_dst_c = RD_RT;
                    to_reg_c  = TR_ALU;
                end
                state_d = S_FETCH;
            end

            S_TRAP: begin
                illegal_c = 1'b1;
                state_d   = S_TRAP;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by rstn so nothing fires while reset is held, even in FETCH.
    assign PCWrite  = rstn & pc_write_c;
    assign IRWrite  = rstn & ir_write_c;
    assign RegWrite = rstn & reg_write_c;
    assign MemRead  = rstn & mem_read_c;
    assign MemWrite = rstn & mem_write_c;
    assign illegal  = rstn & illegal_c;
    assign RegDst   = reg_dst_c;
    assign ALUSrc   = alu_src_c;
    assign ToReg    = to_reg_c;
    assign ALUOp    = alu_op_c;
    assign NPCOp    = npc_op_c;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized instruction
// streams checked cycle-by-cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
    logic [1:0] RegDst, ALUSrc, ToReg, NPCOp;
    logic [3:0] ALUOp;
    logic [2:0] state;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ToReg(ToReg), .ALUOp(ALUOp),
        .NPCOp(NPCOp), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, RegDst, ALUSrc,
                  ToReg, ALUOp, NPCOp, state, illegal};

    localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_JR = 5, K_J = 6, K_JAL = 7;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         kind;
        logic [1:0] asrc;
        logic [3:0] aop;
    } ins_t;

    ins_t tab [16];

    function automatic logic [20:0] ev(input logic pc, input logic ir, input logic rw,
                                       input logic mr, input logic mw, input logic [1:0] rd,
                                       input logic [1:0] as, input logic [1:0] tr,
                                       input logic [3:0] ao, input logic [1:0] np,
                                       input logic [2:0] st, input logic il);
        return {pc, ir, rw, mr, mw, rd, as, tr, ao, np, st, il};
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic cyc(input string tag, input logic [20:0] exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int idx, input int fw, input int mw, input int zsel);
        ins_t t;
        logic z;
        t = tab[idx];
        op = t.op;
        funct = (t.kind == K_R || t.kind == K_JR) ? t.funct : 6'($urandom);
        for (int w = 0; w < fw; w++) begin
            mem_ready = 1'b0; zero = 1'($urandom);
            cyc("fetch_wait", ev(0,0,0,1,0,0,0,0,0,0,0,0));
        end
        mem_ready = 1'b1; zero = 1'($urandom);
        cyc("fetch", ev(1,1,0,1,0,0,0,0,0,0,0,0));
        mem_ready = 1'($urandom); zero = 1'($urandom);
        if (t.kind == K_J) begin
            cyc("decode_j", ev(1,0,0,0,0,0,0,0,0,2,1,0));
            return;
        end
        if (t.kind == K_JAL) begin
            cyc("decode_jal", ev(1,0,1,0,0,2,0,2,0,2,1,0));
            return;
        end
        cyc("decode", ev(0,0,0,0,0,0,0,0,0,0,1,0));
        // The IR fields are scrambled from here on; the class register must carry the instruction.
        op = 6'($urandom); funct = 6'($urandom);
        mem_ready = 1'($urandom);
        z = (zsel < 0) ? 1'($urandom) : zsel[0];
        zero = z;
        case (t.kind)
            K_BEQ: begin
                cyc("exec_beq", ev(z,0,0,0,0,0,0,0,1,1,2,0));
                return;
            end
            K_JR: begin
                cyc("exec_jr", ev(1,0,0,0,0,0,0,0,0,3,2,0));
                return;
            end
            default: cyc("exec", ev(0,0,0,0,0,0,t.asrc,0,t.aop,0,2,0));
        endcase
        if (t.kind == K_LW || t.kind == K_SW) begin
            for (int w = 0; w < mw; w++) begin
                mem_ready = 1'b0; zero = 1'($urandom);
                cyc("mem_wait", ev(0,0,0,t.kind == K_LW,t.kind == K_SW,0,0,0,0,0,3,0));
            end
            mem_ready = 1'b1;
            cyc("mem", ev(0,0,0,t.kind == K_LW,t.kind == K_SW,0,0,0,0,0,3,0));
            if (t.kind == K_SW) return;
        end
        mem_ready = 1'($urandom); zero = 1'($urandom);
        cyc("wb", ev(0,0,1,0,0,(t.kind == K_R) ? 2'b01 : 2'b00, t.asrc,
                     (t.kind == K_LW) ? 2'b00 : 2'b01, t.aop, 0, 4, 0));
    endtask

    // Reset pulse placed mid-cycle, away from any rising edge.
    task automatic pulse_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        chk(tag, ev(0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk({tag, "_held"}, ev(0,0,0,0,0,0,0,0,0,0,0,0));
        rstn = 1'b1;
        mem_ready = 1'b0;
        cyc({tag, "_fetch"}, ev(0,0,0,1,0,0,0,0,0,0,0,0));
    endtask

    task automatic run_illegal(input logic [5:0] o, input logic [5:0] f);
        op = o; funct = f; mem_ready = 1'b1;
        cyc("ill_fetch", ev(1,1,0,1,0,0,0,0,0,0,0,0));
        mem_ready = 1'($urandom);
        cyc("ill_decode", ev(0,0,0,0,0,0,0,0,0,0,1,0));
        for (int k = 0; k < 10; k++) begin
            op = 6'($urandom); funct = 6'($urandom);
            mem_ready = 1'($urandom); zero = 1'($urandom);
            cyc("trap", ev(0,0,0,0,0,0,0,0,0,0,5,1));
        end
        pulse_reset("trap_reset");
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog observed=timeout expected=finish");
    end

    initial begin
        tab[0]  = '{6'b000000, 6'b100000, K_R,   2'b00, 4'd0};
        tab[1]  = '{6'b000000, 6'b100010, K_R,   2'b00, 4'd1};
        tab[2]  = '{6'b000000, 6'b100100, K_R,   2'b00, 4'd2};
        tab[3]  = '{6'b000000, 6'b100101, K_R,   2'b00, 4'd3};
        tab[4]  = '{6'b000000, 6'b101010, K_R,   2'b00, 4'd4};
        tab[5]  = '{6'b000000, 6'b000000, K_R,   2'b10, 4'd5};
        tab[6]  = '{6'b000000, 6'b000010, K_R,   2'b10, 4'd6};
        tab[7]  = '{6'b000000, 6'b001000, K_JR,  2'b00, 4'd0};
        tab[8]  = '{6'b100011, 6'b000000, K_LW,  2'b01, 4'd0};
        tab[9]  = '{6'b101011, 6'b000000, K_SW,  2'b01, 4'd0};
        tab[10] = '{6'b000100, 6'b000000, K_BEQ, 2'b00, 4'd1};
        tab[11] = '{6'b001000, 6'b000000, K_IMM, 2'b01, 4'd0};
        tab[12] = '{6'b001101, 6'b000000, K_IMM, 2'b01, 4'd3};
        tab[13] = '{6'b001111, 6'b000000, K_IMM, 2'b01, 4'd7};
        tab[14] = '{6'b000010, 6'b000000, K_J,   2'b00, 4'd0};
        tab[15] = '{6'b000011, 6'b000000, K_JAL, 2'b00, 4'd0};

        rstn = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_state", ev(0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("reset_edge", ev(0,0,0,0,0,0,0,0,0,0,0,0));
        rstn = 1'b1;

        run_instr(0, 0, 0, -1);
        run_instr(8, 1, 3, -1);
        run_instr(10, 0, 0, 0);
        run_instr(10, 0, 0, 1);
        run_instr(15, 0, 0, -1);
        run_instr(14, 2, 0, -1);
        run_instr(7, 0, 0, -1);
        for (int i = 5; i <= 6; i++) run_instr(i, 0, 0, -1);
        for (int i = 11; i <= 13; i++) run_instr(i, 0, 0, -1);

        // sw interrupted by reset while waiting in MEM.
        op = 6'b101011; funct = 6'($urandom); mem_ready = 1'b1;
        cyc("sw_fetch", ev(1,1,0,1,0,0,0,0,0,0,0,0));
        cyc("sw_decode", ev(0,0,0,0,0,0,0,0,0,0,1,0));
        cyc("sw_exec", ev(0,0,0,0,0,0,1,0,0,0,2,0));
        mem_ready = 1'b0;
        cyc("sw_mem_wait", ev(0,0,0,0,1,0,0,0,0,0,3,0));
        #1;
        chk("sw_mem_pre_reset", ev(0,0,0,0,1,0,0,0,0,0,3,0));
        pulse_reset("sw_reset");

        // lw interrupted by reset in WB: RegWrite must not survive.
        op = 6'b100011; mem_ready = 1'b1;
        cyc("lw_fetch", ev(1,1,0,1,0,0,0,0,0,0,0,0));
        cyc("lw_decode", ev(0,0,0,0,0,0,0,0,0,0,1,0));
        cyc("lw_exec", ev(0,0,0,0,0,0,1,0,0,0,2,0));
        cyc("lw_mem", ev(0,0,0,1,0,0,0,0,0,0,3,0));
        pulse_reset("lw_wb_reset");

        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), -1);
        end

        run_illegal(6'b111111, 6'b000000);
        run_illegal(6'b000000, 6'b111111);
        run_instr(0, 0, 0, -1);
        run_instr(8, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
